// File: rtl/custom_acc_mc_shell.sv
// custom_acc_mc_shell: multi-channel accelerator shell with config FIFOs, NOC1 arbitration and MSHR slot tracking
module custom_acc_mc_shell #(
  parameter int NUM_CH = 4,
  parameter int CMD_DEPTH = 16,
  parameter int RESP_DEPTH = 4,
  parameter int MAX_OUT = 16,
  parameter logic [63:0] EMPTY_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter logic [5:0] STATUS_OP = 6'h3F,
  parameter int MSG_TYPE_WIDTH = 8,
  parameter logic [MSG_TYPE_WIDTH-1:0] DREAM_NS_LOAD = 'd60,
  parameter logic [MSG_TYPE_WIDTH-1:0] DREAM_SW_WB = 'd61,
  parameter logic [2:0] MSG_DATA_SIZE_16B = 3'b101
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        config_hsk,
  input  logic [19:0]                 config_addr,
  input  logic [31:0]                 config_data_hi,
  input  logic [31:0]                 config_data_lo,
  input  logic                        config_load,
  input  logic                        noc1buffer_rdy,
  output logic                        noc1buffer_val,
  output logic [MSG_TYPE_WIDTH-1:0]   noc1buffer_type,
  output logic [7:0]                  noc1buffer_mshrid,
  output logic [39:0]                 noc1buffer_address,
  output logic [2:0]                  noc1buffer_size,
  output logic [63:0]                 noc1buffer_data_0,
  output logic [63:0]                 noc1buffer_data_1,
  output logic [15:0]                 noc1buffer_write_mask,
  input  logic                        noc2decoder_val,
  input  logic [7:0]                  noc2decoder_mshrid,
  input  logic [127:0]                noc2decoder_data,
  output logic [63:0]                 read_to_ariane_data,
  output logic                        read_to_ariane_val,
  output logic [NUM_CH-1:0]           ch_cmd_val,
  input  logic [NUM_CH-1:0]           ch_cmd_rdy,
  output logic [NUM_CH*6-1:0]         ch_cmd_opcode,
  output logic [NUM_CH*64-1:0]        ch_cmd_data,
  input  logic [NUM_CH-1:0]           ch_mem_req_val,
  output logic [NUM_CH-1:0]           ch_mem_req_rdy,
  input  logic [NUM_CH-1:0]           ch_mem_req_store,
  input  logic [NUM_CH*40-1:0]        ch_mem_req_addr,
  input  logic [NUM_CH*128-1:0]       ch_mem_req_wdata,
  input  logic [NUM_CH*16-1:0]        ch_mem_req_mask,
  output logic [$clog2(MAX_OUT)-1:0]  ch_mem_req_tag,
  output logic [NUM_CH-1:0]           ch_mem_resp_val,
  output logic [$clog2(MAX_OUT)-1:0]  ch_mem_resp_tag,
  output logic [127:0]                ch_mem_resp_data,
  input  logic [NUM_CH-1:0]           ch_resp_val,
  output logic [NUM_CH-1:0]           ch_resp_rdy,
  input  logic [NUM_CH*64-1:0]        ch_resp_data
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SW = $clog2(MAX_OUT);
  localparam int CAW = CMD_DEPTH > 1 ? $clog2(CMD_DEPTH) : 1;
  localparam int RAW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  logic [5:0] op;
  logic [CW-1:0] sel, rch, rr, gnt;
  logic [SW-1:0] rslot;
  logic is_stat, ld, st, rsp_ok, gv, stage_free, unused_ok;
  logic [NUM_CH-1:0] elig, acc_v, rnempty;
  logic [63:0] stat_w [NUM_CH];
  logic [63:0] rhead [NUM_CH];
  logic [SW-1:0] fs [NUM_CH];
  assign op = config_addr[8:3];
  assign sel = config_addr[9 +: CW] & CW'(NUM_CH - 1);
  assign is_stat = op == STATUS_OP;
  assign ld = config_hsk & config_load;
  assign st = config_hsk & !config_load & !is_stat;
  assign rsp_ok = noc2decoder_val & (noc2decoder_mshrid[7:6] == 2'b11);
  assign rch = noc2decoder_mshrid[SW +: CW] & CW'(NUM_CH - 1);
  assign rslot = noc2decoder_mshrid[SW-1:0];
  assign ch_mem_resp_tag = rslot;
  assign ch_mem_resp_data = noc2decoder_data;
  assign stage_free = !noc1buffer_val | noc1buffer_rdy;
  assign ch_mem_req_rdy = acc_v;
  assign ch_mem_req_tag = fs[gnt];
  assign noc1buffer_size = MSG_DATA_SIZE_16B;
  assign unused_ok = ^{config_addr, noc2decoder_mshrid};
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [69:0] cmem [CMD_DEPTH];
    logic [63:0] rmem [RESP_DEPTH];
    logic [CAW-1:0] cwp, crp;
    logic [RAW-1:0] rwp, rrp;
    logic [CAW:0] ccnt;
    logic [RAW:0] rcnt;
    logic [MAX_OUT-1:0] al, al_set, al_clr;
    logic [SW-1:0] lf;
    logic hit, cpush, cpop, cacc, rpush, rpop, srd, ov, orp, own;
    assign hit = sel == CW'(c);
    assign cpush = st & hit;
    assign cpop = ch_cmd_val[c] & ch_cmd_rdy[c];
    assign cacc = cpush & ((ccnt != (CAW+1)'(CMD_DEPTH)) | cpop);
    assign ch_cmd_val[c] = ccnt != '0;
    assign ch_cmd_opcode[c*6 +: 6] = ch_cmd_val[c] ? cmem[crp][69:64] : '0;
    assign ch_cmd_data[c*64 +: 64] = ch_cmd_val[c] ? cmem[crp][63:0] : '0;
    assign ch_resp_rdy[c] = rcnt != (RAW+1)'(RESP_DEPTH);
    assign rpush = ch_resp_val[c] & ch_resp_rdy[c];
    assign rnempty[c] = rcnt != '0;
    assign rpop = ld & !is_stat & hit & rnempty[c];
    assign srd = ld & is_stat & hit;
    assign rhead[c] = rmem[rrp];
    assign own = rsp_ok & (rch == CW'(c));
    assign al_clr = (own & al[rslot]) ? MAX_OUT'(1) << rslot : '0;
    assign al_set = acc_v[c] ? MAX_OUT'(1) << lf : '0;
    assign ch_mem_resp_val[c] = own & al[rslot];
    assign elig[c] = ch_mem_req_val[c] & ~&al;
    assign fs[c] = lf;
    assign stat_w[c] = {39'b0, 7'($countones(al)), orp, ov, 8'(ccnt), 8'(rcnt)};
    always_comb begin
      lf = '0;
      for (int i = MAX_OUT - 1; i >= 0; i--) if (!al[i]) lf = SW'(i);
    end
    always_ff @(posedge clk) begin
      if (cacc) cmem[cwp] <= {op, config_data_hi, config_data_lo};
      if (rpush) rmem[rwp] <= ch_resp_data[c*64 +: 64];
    end
    // a slot freed by a response this cycle was never visible to lf, so set/clear cannot collide
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cwp <= '0;
        crp <= '0;
        ccnt <= '0;
        rwp <= '0;
        rrp <= '0;
        rcnt <= '0;
        al <= '0;
        ov <= 1'b0;
        orp <= 1'b0;
      end else begin
        if (cacc) cwp <= cwp == CAW'(CMD_DEPTH - 1) ? '0 : cwp + CAW'(1);
        if (cpop) crp <= crp == CAW'(CMD_DEPTH - 1) ? '0 : crp + CAW'(1);
        if (rpush) rwp <= rwp == RAW'(RESP_DEPTH - 1) ? '0 : rwp + RAW'(1);
        if (rpop) rrp <= rrp == RAW'(RESP_DEPTH - 1) ? '0 : rrp + RAW'(1);
        ccnt <= ccnt + (CAW+1)'(cacc) - (CAW+1)'(cpop);
        rcnt <= rcnt + (RAW+1)'(rpush) - (RAW+1)'(rpop);
        al <= (al & ~al_clr) | al_set;
        ov <= (ov & !srd) | (cpush & !cacc);
        orp <= (orp & !srd) | (own & !al[rslot]);
      end
    end
  end
  // rr holds the highest-priority channel for the next grant
  always_comb begin
    gnt = '0;
    gv = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[(int'(rr) + i) % NUM_CH]) begin
        gnt = CW'((int'(rr) + i) % NUM_CH);
        gv = 1'b1;
      end
    end
  end
  assign acc_v = (gv & stage_free) ? NUM_CH'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
      noc1buffer_val <= 1'b0;
      noc1buffer_type <= '0;
      noc1buffer_mshrid <= '0;
      noc1buffer_address <= '0;
      noc1buffer_data_0 <= '0;
      noc1buffer_data_1 <= '0;
      noc1buffer_write_mask <= '0;
      read_to_ariane_val <= 1'b0;
      read_to_ariane_data <= '0;
    end else begin
      read_to_ariane_val <= ld;
      if (ld) read_to_ariane_data <= is_stat ? stat_w[sel] : rnempty[sel] ? rhead[sel] : EMPTY_PATTERN;
      if (gv & stage_free) begin
        noc1buffer_val <= 1'b1;
        rr <= CW'((int'(gnt) + 1) % NUM_CH);
        noc1buffer_type <= ch_mem_req_store[gnt] ? DREAM_SW_WB : DREAM_NS_LOAD;
        noc1buffer_mshrid <= {2'b11, 6'({gnt, fs[gnt]})};
        noc1buffer_address <= ch_mem_req_addr[gnt*40 +: 40];
        noc1buffer_data_0 <= ch_mem_req_store[gnt] ? ch_mem_req_wdata[gnt*128 +: 64] : '0;
        noc1buffer_data_1 <= ch_mem_req_store[gnt] ? ch_mem_req_wdata[gnt*128+64 +: 64] : '0;
        noc1buffer_write_mask <= ch_mem_req_store[gnt] ? ch_mem_req_mask[gnt*16 +: 16] : '0;
      end else if (noc1buffer_rdy) noc1buffer_val <= 1'b0;
    end
  end
endmodule
